// File: rtl/spike_output_arbiter.sv
// Packet-aware round-robin arbiter: N_REQ requesters share one registered
// output channel. A winner keeps the channel until it delivers its last flit.
// Saturating counters report completed packets per source and output stalls.

// Saturating up-counter; holds at all-ones instead of wrapping.
module satCounter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  // count up on inc, stick at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end
endmodule

module spike_output_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ*WIDTH-1:0] in_data,
  input  logic [N_REQ-1:0]       in_last,
  output logic [N_REQ-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [N_REQ*CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0]       stall_count
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [SRC_W:0] NREQ_EXT = (SRC_W+1)'(N_REQ);

  state_t             state, stateNext;
  logic [SRC_W-1:0]   owner, ownerNext;
  logic [SRC_W-1:0]   ptr, ptrNext;

  logic               found;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   scanIdx;
  logic [SRC_W-1:0]   grantIdx;
  logic               grantVld;
  logic               loadEn;
  logic               xfer;
  logic               xferLast;
  logic [WIDTH-1:0]   selData;
  logic [N_REQ-1:0]   pktInc;
  logic               stallInc;

  // (a + b) mod N_REQ for a, b < N_REQ, without a divider
  function automatic logic [SRC_W-1:0] wrapAdd(input logic [SRC_W-1:0] a,
                                               input logic [SRC_W-1:0] b);
    logic [SRC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= NREQ_EXT) sum = sum - NREQ_EXT;
    return sum[SRC_W-1:0];
  endfunction

  // the output register can take a flit when it is empty or being drained
  assign loadEn = !out_valid || out_ready;

  // round-robin scan starting at ptr; first valid requester wins
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    scanIdx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scanIdx = wrapAdd(ptr, SRC_W'(k));
      if (!found && in_valid[scanIdx]) begin
        found  = 1'b1;
        winner = scanIdx;
      end
    end
  end

  // a locked owner is the only candidate; otherwise the scan winner
  always_comb begin
    grantIdx = (state == LOCK) ? owner : winner;
    grantVld = (state == LOCK) || found;
  end

  // one-hot ready toward the granted requester; no path from in_data
  always_comb begin
    in_ready = '0;
    if (grantVld && loadEn) in_ready[grantIdx] = 1'b1;
  end

  assign xfer     = in_valid[grantIdx] && in_ready[grantIdx];
  assign xferLast = xfer && in_last[grantIdx];

  // data mux for the granted requester
  always_comb begin
    selData = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grantIdx == SRC_W'(i)) selData = in_data[i*WIDTH +: WIDTH];
  end

  // arbitration state, lock owner and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      owner <= ownerNext;
      ptr   <= ptrNext;
    end
  end

  // next state: lock on a non-last flit, release and advance ptr on the last
  always_comb begin
    stateNext = state;
    ownerNext = owner;
    ptrNext   = ptr;
    case (state)
      IDLE: begin
        if (xfer && !in_last[grantIdx]) begin
          stateNext = LOCK;
          ownerNext = grantIdx;
        end else if (xferLast) begin
          ptrNext = wrapAdd(grantIdx, SRC_W'(1));
        end
      end
      LOCK: begin
        if (xferLast) begin
          stateNext = IDLE;
          ptrNext   = wrapAdd(owner, SRC_W'(1));
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // output register: load on transfer, empty when drained with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= selData;
      out_src   <= grantIdx;
      out_last  <= in_last[grantIdx];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // per-source packet-completion strobes
  always_comb begin
    pktInc = '0;
    if (xferLast) pktInc[grantIdx] = 1'b1;
  end

  assign stallInc = out_valid && !out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : gPkt
      satCounter #(.W(CNT_W)) uPkt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pktInc[gi]),
        .count (pkt_count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  satCounter #(.W(CNT_W)) uStall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stallInc),
    .count (stall_count)
  );

endmodule

// File: tb/tb_spike_output_arbiter.sv
// Bench for spike_output_arbiter: directed scenarios with literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_spike_output_arbiter;
  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int CW2 = 4;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     in_valid = '0;
  logic [NR*W-1:0]   in_data = '0;
  logic [NR-1:0]     in_last = '0;
  logic              out_ready = 1'b1;

  logic [NR-1:0]     in_ready, in_ready2;
  logic              out_valid, out_valid2;
  logic [W-1:0]      out_data, out_data2;
  logic [SW-1:0]     out_src, out_src2;
  logic              out_last, out_last2;
  logic [NR*CW-1:0]  pkt_count;
  logic [NR*CW2-1:0] pkt_count2;
  logic [CW-1:0]     stall_count;
  logic [CW2-1:0]    stall_count2;

  int total = 0;
  int bad   = 0;

  spike_output_arbiter #(.N_REQ(NR), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .pkt_count(pkt_count), .stall_count(stall_count));

  spike_output_arbiter #(.N_REQ(NR), .WIDTH(W), .CNT_W(CW2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready2), .out_valid(out_valid2),
    .out_data(out_data2), .out_src(out_src2), .out_last(out_last2),
    .out_ready(out_ready), .pkt_count(pkt_count2), .stall_count(stall_count2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mPtr = 0;
  int          mOwner = -1;
  bit          mOv = 0;
  logic [W-1:0] mData = '0;
  int          mSrc = 0;
  bit          mLast = 0;
  int          mStall = 0;
  int          mPkt[NR];

  function automatic int grantOf();
    if (mOwner >= 0) return mOwner;
    for (int k = 0; k < NR; k++)
      if (in_valid[(mPtr + k) % NR]) return (mPtr + k) % NR;
    return -1;
  endfunction

  function automatic bit canLoad();
    return !mOv || out_ready;
  endfunction

  function automatic bit xferNow();
    int g;
    g = grantOf();
    if (g < 0) return 0;
    return in_valid[g] && canLoad();
  endfunction

  function automatic logic [NR-1:0] expReady();
    logic [NR-1:0] r;
    int g;
    r = '0;
    g = grantOf();
    if (g >= 0 && canLoad()) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] sat(input int v, input int bits);
    int mx;
    mx = (1 << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOv <= 0; mData <= '0; mSrc <= 0; mLast <= 0;
      mPtr <= 0; mOwner <= -1; mStall <= 0;
      for (int i = 0; i < NR; i++) mPkt[i] <= 0;
    end else begin
      if (mOv && !out_ready) mStall <= mStall + 1;
      if (xferNow()) begin
        mOv   <= 1;
        mData <= in_data[grantOf()*W +: W];
        mSrc  <= grantOf();
        mLast <= in_last[grantOf()];
        if (in_last[grantOf()]) begin
          mOwner <= -1;
          mPtr   <= (grantOf() + 1) % NR;
          mPkt[grantOf()] <= mPkt[grantOf()] + 1;
        end else begin
          mOwner <= grantOf();
        end
      end else if (out_ready) begin
        mOv <= 0;
      end
    end
  end

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(expReady()));
      chk("out_valid", 32'(out_valid), 32'(mOv));
      chk("in_ready_c4", 32'(in_ready2), 32'(expReady()));
      chk("out_valid_c4", 32'(out_valid2), 32'(mOv));
      if (mOv) begin
        chk("out_data", 32'(out_data), 32'(mData));
        chk("out_src", 32'(out_src), 32'(mSrc));
        chk("out_last", 32'(out_last), 32'(mLast));
        chk("out_data_c4", 32'(out_data2), 32'(mData));
      end
      for (int i = 0; i < NR; i++) begin
        chk("pkt_count", 32'(pkt_count[i*CW +: CW]), sat(mPkt[i], CW));
        chk("pkt_count_c4", 32'(pkt_count2[i*CW2 +: CW2]), sat(mPkt[i], CW2));
      end
      chk("stall_count", 32'(stall_count), sat(mStall, CW));
      chk("stall_count_c4", 32'(stall_count2), sat(mStall, CW2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(output logic [NR-1:0] hs);
    @(negedge clk);
    hs = in_valid & in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] pk(input int i);
    return 32'(pkt_count[i*CW +: CW]);
  endfunction

  int rem[NR];

  initial begin
    logic [NR-1:0] hs;

    // reset, idle for 10 cycles
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_ov", 32'(out_valid), 0);
      chk("idle_rdy", 32'(in_ready), 0);
      chk("idle_stall", 32'(stall_count), 0);
      chk("idle_pkt", 32'(pkt_count), 0);
    end
    @(posedge clk); #1;

    // four single-flit packets, served 0,1,2,3 back to back
    in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < NR; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
    #1;
    for (int c = 0; c < NR; c++) begin
      step(hs);
      in_valid = in_valid & ~hs;
      chk("rr_src", 32'(out_src), c);
      chk("rr_data", 32'(out_data), 32'h10 + c);
      chk("rr_ov", 32'(out_valid), 1);
      #1;
    end
    for (int i = 0; i < NR; i++) chk("rr_pkt", pk(i), 1);

    // 3-flit packet from 1 holds off requester 2
    in_valid = 4'b0110; in_last = 4'b0100;
    in_data[1*W +: W] = 8'hA1; in_data[2*W +: W] = 8'hB0;
    #1;
    step(hs);
    chk("lk_hs1", 32'(hs), 32'b0010);
    chk("lk_d1", 32'(out_data), 32'hA1);
    chk("lk_s1", 32'(out_src), 1);
    in_data[1*W +: W] = 8'hA2; #1;
    chk("lk_rdy1", 32'(in_ready), 32'b0010);
    step(hs);
    chk("lk_d2", 32'(out_data), 32'hA2);
    in_data[1*W +: W] = 8'hA3; in_last[1] = 1'b1; #1;
    chk("lk_rdy2", 32'(in_ready[2]), 0);
    step(hs);
    chk("lk_d3", 32'(out_data), 32'hA3);
    chk("lk_s3", 32'(out_src), 1);
    chk("lk_l3", 32'(out_last), 1);
    in_valid[1] = 1'b0; #1;
    step(hs);
    chk("lk_d4", 32'(out_data), 32'hB0);
    chk("lk_s4", 32'(out_src), 2);
    in_valid = '0; #1;

    // 5-cycle stall with 8'h5A in the output register
    doReset();
    in_valid = 4'b0001; in_last = 4'b0001; in_data[0 +: W] = 8'h5A; out_ready = 1'b0;
    #1;
    step(hs);
    chk("st_ov", 32'(out_valid), 1);
    in_valid = 4'b0010; in_last = 4'b0010; in_data[1*W +: W] = 8'h77; #1;
    chk("st_rdy0", 32'(in_ready), 0);
    for (int c = 0; c < 5; c++) begin
      step(hs);
      chk("st_hold", 32'(out_data), 32'h5A);
      chk("st_rdy", 32'(in_ready), 0);
    end
    chk("st_cnt", 32'(stall_count), 5);
    out_ready = 1'b1; #1;
    chk("st_resume_rdy", 32'(in_ready), 32'b0010);
    step(hs);
    chk("st_resume_hs", 32'(hs), 32'b0010);
    chk("st_resume_d", 32'(out_data), 32'h77);
    in_valid = '0; #1;

    // owner 0 pauses mid-packet; requester 3 must wait
    doReset();
    in_valid = 4'b1001; in_last = 4'b1000;
    in_data[0 +: W] = 8'hC1; in_data[3*W +: W] = 8'hD3;
    #1;
    step(hs);
    chk("gap_s0", 32'(out_src), 0);
    in_valid[0] = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      chk("gap_rdy3", 32'(in_ready[3]), 0);
      step(hs);
      chk("gap_hs", 32'(hs), 0);
    end
    in_valid[0] = 1'b1; in_last[0] = 1'b1; in_data[0 +: W] = 8'hC2; #1;
    step(hs);
    chk("gap_last_hs", 32'(hs), 32'b0001);
    chk("gap_last_d", 32'(out_data), 32'hC2);
    in_valid[0] = 1'b0; #1;
    chk("gap_rdy_next", 32'(in_ready), 32'b1000);
    step(hs);
    chk("gap_s3", 32'(out_src), 3);
    chk("gap_d3", 32'(out_data), 32'hD3);
    in_valid = '0; #1;

    // asynchronous reset in the middle of a packet
    doReset();
    in_valid = 4'b0010; in_last = 4'b0000; in_data[1*W +: W] = 8'hE1; #1;
    step(hs);
    chk("ar_ov_pre", 32'(out_valid), 1);
    rst_n = 1'b0; in_valid = '0;
    #1;
    chk("ar_ov_async", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    in_valid = 4'b0100; in_last = 4'b0100; in_data[2*W +: W] = 8'hF2; #1;
    step(hs);
    chk("ar_src", 32'(out_src), 2);
    chk("ar_data", 32'(out_data), 32'hF2);
    chk("ar_pkt2", pk(2), 1);
    chk("ar_pkt1", pk(1), 0);
    in_valid = '0; #1;

    // 20 packets from requester 0; 4-bit counter stops at 15
    doReset();
    in_valid = 4'b0001; in_last = 4'b0001; in_data[0 +: W] = 8'h33; #1;
    for (int c = 0; c < 20; c++) step(hs);
    in_valid = '0; #1;
    chk("sat_pkt16", pk(0), 20);
    chk("sat_pkt4", 32'(pkt_count2[0 +: CW2]), 15);

    // randomized traffic against the model
    doReset();
    for (int i = 0; i < NR; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      step(hs);
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          if (rem[i] == 1) begin
            in_valid[i] = 1'b0;
            rem[i] = 0;
          end else begin
            rem[i] = rem[i] - 1;
            in_valid[i] = ($urandom_range(0, 3) != 0);
            in_data[i*W +: W] = 8'($urandom);
            in_last[i] = (rem[i] == 1);
          end
        end else if (!in_valid[i]) begin
          if (rem[i] > 0) begin
            if ($urandom_range(0, 1) == 1) in_valid[i] = 1'b1;
          end else if ($urandom_range(0, 2) == 0) begin
            rem[i] = $urandom_range(1, 4);
            in_valid[i] = 1'b1;
            in_data[i*W +: W] = 8'($urandom);
            in_last[i] = (rem[i] == 1);
          end
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
